// File: rtl/gate_sweep_sequencer.sv
// Truth-table sweeper for the trainer's gate unit: walks every sel/a/b vector,
// captures y after a settle delay and grades the table against a golden image.
//
//   state   | meaning
//   S_IDLE  | waiting for start, outputs hold
//   S_SETTLE| vector applied, settle timer running
//   S_CAPTURE| sample gate_y into the table, advance or finish
//   S_DONE  | table complete, verdict valid, waiting for start
module gate_sweep_sequencer #(
  parameter int unsigned NUM_GATES     = 7,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] EXPECTED      = 32'h039617E8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   ena_i,
  input  logic                   start_i,
  input  logic                   gate_y_i,
  output logic [2:0]             gate_sel_o,
  output logic                   gate_a_o,
  output logic                   gate_b_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NUM_GATES-1:0] result_o,
  output logic                   mismatch_o,
  output logic [4:0]             fail_idx_o
);

  localparam int unsigned NBITS = 4 * NUM_GATES;
  localparam int unsigned CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX = 5'(NBITS - 1);
  localparam logic [NBITS-1:0] GOLDEN   = EXPECTED[NBITS-1:0];

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       vec_q, vec_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [4:0]       fail_idx_q, fail_idx_d;

  function automatic logic [4:0] first_diff(input logic [NBITS-1:0] diff);
    first_diff = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = 5'(i);
    end
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // The vector index doubles as the table bit index: {sel, a, b}.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mismatch_d = mismatch_q;
    fail_idx_d = fail_idx_q;
    if (ena_i) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            vec_d      = '0;
            cnt_d      = CNT_LOAD;
            result_d   = '0;
            done_d     = 1'b0;
            mismatch_d = 1'b0;
            fail_idx_d = '0;
            busy_d     = 1'b1;
            state_d    = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_CAPTURE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_CAPTURE: begin
          for (int i = 0; i < NBITS; i++) begin
            if (vec_q == 5'(i)) result_d[i] = gate_y_i;
          end
          // Verdict uses result_d so the bit captured on this edge is graded too.
          if (vec_q == LAST_IDX) begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            mismatch_d = (result_d != GOLDEN);
            fail_idx_d = first_diff(result_d ^ GOLDEN);
          end else begin
            vec_d   = vec_q + 5'd1;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign gate_sel_o = vec_q[4:2];
  assign gate_a_o   = vec_q[1];
  assign gate_b_o   = vec_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign mismatch_o = mismatch_q;
  assign fail_idx_o = fail_idx_q;

endmodule
